pipe_stall_ctrl: RTL and testbench

- Central stall/flush controller for the 5-stage pipeline. Produces the per-stage stall vector consumed by pc_reg, the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Detects load-use hazards that the ID-stage forwarding paths cannot cover.
- Sequences multi-cycle EX operations (mult/div class) by holding the front of the pipe for N cycles.
- Issues a one-cycle flush on request and keeps a saturating stall-cycle performance counter.

---
 rtl/pipe_stall_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_pipe_stall_ctrl.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stall_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline.
//
// The controller produces three things:
//   * a per-stage stall vector (PC, IF, ID, EX, MEM, WB),
//   * a one-cycle flush strobe,
//   * a saturating count of cycles in which the ID stage was held.
//
// Two sources can stall the pipe:
//   * A load-use hazard. A load in EX produces a register that ID needs now,
//     and the forwarding paths cannot supply it yet. This source holds PC/IF/ID
//     for one cycle, and it clears on its own once the load leaves EX.
//   * A multi-cycle EX operation (the mult/div class). This source holds
//     PC/IF/ID/EX for the full occupancy of the operation. It is sequenced by
//     a small IDLE/MULTI state machine with a down-counter.
//
// A flush request overrides everything. In the cycle it is asserted, flush is
// high and no stage is stalled. Any multi-cycle sequence in progress is
// abandoned.
//
// The stall bits for MEM and WB are reserved and are always driven to zero.
// Downstream stages must still honour them.
//
// Handshake: there is no valid/ready pairing in this block. Every input is a
// level that is sampled each cycle. stall and flush are combinational
// responses in that same cycle. ex_multi_start is a single-cycle pulse that is
// honoured only in IDLE.

module pipe_stall_ctrl #(
    parameter int CNT_W  = 6,
    parameter int PERF_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_reg1_read,
    input  logic [4:0]        id_reg1_addr,
    input  logic              id_reg2_read,
    input  logic [4:0]        id_reg2_addr,
    input  logic              ex_is_load,
    input  logic              ex_wreg,
    input  logic [4:0]        ex_wd,
    input  logic              ex_multi_start,
    input  logic [CNT_W-1:0]  ex_multi_cycles,
    input  logic              flush_req,
    output logic [5:0]        stall,
    output logic              flush,
    output logic              busy,
    output logic [PERF_W-1:0] stall_cycles
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------

    // Sequencer states
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_MULTI = 1'b1;

    // Stall patterns: bit0=PC, bit1=IF, bit2=ID, bit3=EX, bit4=MEM, bit5=WB
    localparam logic [5:0] STALL_NONE     = 6'b000000;
    localparam logic [5:0] STALL_LOAD_USE = 6'b000111;
    localparam logic [5:0] STALL_MULTI    = 6'b001111;

    // Bit of the stall vector that drives the performance counter
    localparam int ID_BIT = 2;

    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ZERO = '0;
    localparam logic [PERF_W-1:0] PERF_MAX = {PERF_W{1'b1}};
    localparam logic [PERF_W-1:0] PERF_ONE = PERF_W'(1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------

    logic [0:0]        state_q;
    logic [0:0]        state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [PERF_W-1:0] stall_cycles_q;
    logic [PERF_W-1:0] stall_cycles_d;

    // ------------------------------------------------------------------
    // Decoded conditions
    // ------------------------------------------------------------------

    logic src1_match;
    logic src2_match;
    logic load_use;
    logic multi_active;
    logic multi_launch;
    logic multi_last;
    logic [5:0] stall_int;
    logic       flush_int;

    // Hazard detect: a load in EX writes a non-zero register that ID reads now.
    // Register $0 never produces a dependency, because it is hard-wired to zero.
    always_comb begin
        src1_match = id_reg1_read && (id_reg1_addr == ex_wd);
        src2_match = id_reg2_read && (id_reg2_addr == ex_wd);
        load_use   = ex_is_load && ex_wreg && (ex_wd != 5'd0)
                     && (src1_match || src2_match);
    end

    // Sequencer conditions.
    // A start pulse launches a sequence only from IDLE, only with no flush in
    // the same cycle, and only when the operation needs two or more cycles.
    // A one-cycle operation completes inside the normal EX slot.
    always_comb begin
        multi_active = (state_q == ST_MULTI);
        multi_launch = (state_q == ST_IDLE) && ex_multi_start && !flush_req
                       && (ex_multi_cycles > CNT_ONE);
        multi_last   = multi_active && (cnt_q == CNT_ONE);
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------

    // Sequencer next state.
    // cnt holds the number of MULTI cycles still to run, including the
    // current one. The start cycle itself is spent in IDLE, so a sequence of
    // N cycles loads N-1.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (flush_req) begin
            state_d = ST_IDLE;
            cnt_d   = CNT_ZERO;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (multi_launch) begin
                        state_d = ST_MULTI;
                        cnt_d   = ex_multi_cycles - CNT_ONE;
                    end
                end
                ST_MULTI: begin
                    if (multi_last) begin
                        state_d = ST_IDLE;
                        cnt_d   = CNT_ZERO;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = CNT_ZERO;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------

    // Output priority: reset, then flush, then multi-cycle hold, then
    // load-use bubble.
    // The load-use check is masked in MULTI, because the multi stall already
    // covers ID.
    always_comb begin
        stall_int = STALL_NONE;
        flush_int = 1'b0;
        if (rst) begin
            stall_int = STALL_NONE;
            flush_int = 1'b0;
        end else if (flush_req) begin
            stall_int = STALL_NONE;
            flush_int = 1'b1;
        end else if (multi_active || multi_launch) begin
            stall_int = STALL_MULTI;
        end else if (load_use) begin
            stall_int = STALL_LOAD_USE;
        end
    end

    // Performance counter next value.
    // The counter advances on every cycle in which ID is held, and it
    // saturates at its maximum instead of wrapping.
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stall_int[ID_BIT] && (stall_cycles_q != PERF_MAX)) begin
            stall_cycles_d = stall_cycles_q + PERF_ONE;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------

    // Register update with synchronous active-high reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            cnt_q          <= CNT_ZERO;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall        = stall_int;
    assign flush        = flush_int;
    assign busy         = multi_active;
    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Testbench for pipe_stall_ctrl.
//
// Two instances share one set of inputs:
//   * dut     uses the default counter width.
//   * dut_sat uses a 4-bit performance counter, so that saturation can be
//     reached quickly.
//
// The reference model tracks the number of multi-cycle stall cycles still
// owed and the count of stalled cycles. On every cycle it predicts the
// outputs from the stated rules, and a single compare process checks both
// instances against that prediction.
//
// Directed scenarios also check hand-computed literal values at key points.

module tb_pipe_stall_ctrl;

    localparam int CNT_W  = 6;
    localparam int PERF_W = 32;
    localparam int SAT_W  = 4;

    // ------------------------------------------------------------------
    // DUT inputs and outputs
    // ------------------------------------------------------------------

    logic              clk;
    logic              rst;
    logic              id_reg1_read;
    logic [4:0]        id_reg1_addr;
    logic              id_reg2_read;
    logic [4:0]        id_reg2_addr;
    logic              ex_is_load;
    logic              ex_wreg;
    logic [4:0]        ex_wd;
    logic              ex_multi_start;
    logic [CNT_W-1:0]  ex_multi_cycles;
    logic              flush_req;

    logic [5:0]        stall;
    logic              flush;
    logic              busy;
    logic [PERF_W-1:0] stall_cycles;

    logic [5:0]        s_stall;
    logic              s_flush;
    logic              s_busy;
    logic [SAT_W-1:0]  s_stall_cycles;

    // ------------------------------------------------------------------
    // Result bookkeeping
    // ------------------------------------------------------------------

    int n_checks = 0;
    int n_fail   = 0;

    // ------------------------------------------------------------------
    // DUT instances
    // ------------------------------------------------------------------

    pipe_stall_ctrl #(
        .CNT_W  (CNT_W),
        .PERF_W (PERF_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .id_reg1_read    (id_reg1_read),
        .id_reg1_addr    (id_reg1_addr),
        .id_reg2_read    (id_reg2_read),
        .id_reg2_addr    (id_reg2_addr),
        .ex_is_load      (ex_is_load),
        .ex_wreg         (ex_wreg),
        .ex_wd           (ex_wd),
        .ex_multi_start  (ex_multi_start),
        .ex_multi_cycles (ex_multi_cycles),
        .flush_req       (flush_req),
        .stall           (stall),
        .flush           (flush),
        .busy            (busy),
        .stall_cycles    (stall_cycles)
    );

    pipe_stall_ctrl #(
        .CNT_W  (CNT_W),
        .PERF_W (SAT_W)
    ) dut_sat (
        .clk             (clk),
        .rst             (rst),
        .id_reg1_read    (id_reg1_read),
        .id_reg1_addr    (id_reg1_addr),
        .id_reg2_read    (id_reg2_read),
        .id_reg2_addr    (id_reg2_addr),
        .ex_is_load      (ex_is_load),
        .ex_wreg         (ex_wreg),
        .ex_wd           (ex_wd),
        .ex_multi_start  (ex_multi_start),
        .ex_multi_cycles (ex_multi_cycles),
        .flush_req       (flush_req),
        .stall           (s_stall),
        .flush           (s_flush),
        .busy            (s_busy),
        .stall_cycles    (s_stall_cycles)
    );

    // ------------------------------------------------------------------
    // Clock, reset and watchdog
    // ------------------------------------------------------------------

    // Clock generation
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog: stop the run if the stimulus never finishes
    initial begin
        #100000;
        $display("FAIL watchdog: act=timeout req=finish");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------
    // Check helper
    // ------------------------------------------------------------------

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: act=0x%0h req=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------

    int          m_rem   = 0;   // multi-cycle stall cycles still owed after the current one
    longint      m_cnt   = 0;   // stalled-cycle count, unbounded
    bit          m_valid = 0;   // set once a reset edge has been seen
    logic [5:0]  m_stall;
    logic        m_flush;
    bit          m_hazard;
    int          m_n;

    // Compare process.
    // Sample on the falling edge, when both the inputs and the registers are
    // stable, then advance the model to match the next rising edge.
    always @(negedge clk) begin
        m_hazard = ex_is_load && ex_wreg && (ex_wd != 0) &&
                   ((id_reg1_read && id_reg1_addr == ex_wd) ||
                    (id_reg2_read && id_reg2_addr == ex_wd));
        m_n = int'(ex_multi_cycles);

        // Predict this cycle's combinational outputs
        m_stall = 6'b000000;
        m_flush = 1'b0;
        if (rst) begin
            m_stall = 6'b000000;
        end else if (flush_req) begin
            m_flush = 1'b1;
        end else if (m_rem > 0 || (ex_multi_start && m_n >= 2)) begin
            m_stall = 6'b001111;
        end else if (m_hazard) begin
            m_stall = 6'b000111;
        end

        // Compare both instances against the prediction
        check("model_stall",     32'(stall),   32'(m_stall));
        check("model_flush",     32'(flush),   32'(m_flush));
        check("model_sat_stall", 32'(s_stall), 32'(m_stall));
        check("model_sat_flush", 32'(s_flush), 32'(m_flush));
        if (m_valid) begin
            check("model_busy",     32'(busy),           32'(m_rem > 0));
            check("model_sat_busy", 32'(s_busy),         32'(m_rem > 0));
            check("model_perf",     stall_cycles,        32'(m_cnt));
            check("model_sat_perf", 32'(s_stall_cycles), (m_cnt > 15) ? 32'd15 : 32'(m_cnt));
        end

        // Advance the model to the next rising edge
        if (rst) begin
            m_rem   = 0;
            m_cnt   = 0;
            m_valid = 1;
        end else begin
            if (m_stall[2]) begin
                m_cnt++;
            end
            if (flush_req) begin
                m_rem = 0;
            end else if (m_rem > 0) begin
                m_rem--;
            end else if (ex_multi_start && m_n >= 2) begin
                m_rem = m_n - 1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------

    task automatic idle_inputs();
        id_reg1_read    = 0;
        id_reg1_addr    = 0;
        id_reg2_read    = 0;
        id_reg2_addr    = 0;
        ex_is_load      = 0;
        ex_wreg         = 0;
        ex_wd           = 0;
        ex_multi_start  = 0;
        ex_multi_cycles = 0;
        flush_req       = 0;
    endtask

    // Wait to the sampling point of the current cycle
    task automatic at_sample();
        @(negedge clk);
    endtask

    // Finish the current cycle; inputs may change after this returns
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Two reset cycles with a pending start pulse that must be ignored,
    // then release and check the cleared state
    task automatic do_reset();
        idle_inputs();
        rst             = 1;
        ex_multi_start  = 1;
        ex_multi_cycles = 6'd5;
        for (int i = 0; i < 2; i++) begin
            at_sample();
            check("rst_stall", 32'(stall), 32'd0);
            check("rst_flush", 32'(flush), 32'd0);
            next_cycle();
        end
        rst = 0;
        idle_inputs();
        at_sample();
        check("rst_busy", 32'(busy),  32'd0);
        check("rst_perf", stall_cycles, 32'd0);
        check("rst_stall_after", 32'(stall), 32'd0);
        next_cycle();
    endtask

    task automatic set_load(input logic [4:0] wd, input logic wreg);
        ex_is_load = 1;
        ex_wreg    = wreg;
        ex_wd      = wd;
    endtask

    // ------------------------------------------------------------------
    // Directed stimulus with literal expectations
    // ------------------------------------------------------------------

    initial begin
        idle_inputs();
        rst = 1;
        next_cycle();
        do_reset();

        // Load-use through source 2: one bubble, counter advances by one
        set_load(5'd5, 1'b1);
        id_reg2_read = 1;
        id_reg2_addr = 5'd5;
        at_sample();
        check("lu2_stall", 32'(stall), 32'h07);
        next_cycle();
        idle_inputs();
        at_sample();
        check("lu2_clear", 32'(stall), 32'h00);
        check("lu2_perf", stall_cycles, 32'd1);
        next_cycle();

        // Load into $0 never creates a hazard
        set_load(5'd0, 1'b1);
        id_reg2_read = 1;
        id_reg2_addr = 5'd0;
        at_sample();
        check("lu_r0_stall", 32'(stall), 32'h00);
        next_cycle();
        idle_inputs();
        at_sample();
        check("lu_r0_perf", stall_cycles, 32'd1);
        next_cycle();

        // Load-use through source 1
        set_load(5'd17, 1'b1);
        id_reg1_read = 1;
        id_reg1_addr = 5'd17;
        at_sample();
        check("lu1_stall", 32'(stall), 32'h07);
        next_cycle();

        // No hazard when the load does not write, or when the address differs
        set_load(5'd17, 1'b0);
        at_sample();
        check("lu_nowreg", 32'(stall), 32'h00);
        next_cycle();
        set_load(5'd18, 1'b1);
        at_sample();
        check("lu_diff_addr", 32'(stall), 32'h00);
        next_cycle();
        idle_inputs();

        // Multi-cycle op, N=4
        do_reset();
        ex_multi_start  = 1;
        ex_multi_cycles = 6'd4;
        for (int c = 1; c <= 5; c++) begin
            at_sample();
            check("m4_stall", 32'(stall), (c <= 4) ? 32'h0F : 32'h00);
            check("m4_busy",  32'(busy),  (c >= 2 && c <= 4) ? 32'd1 : 32'd0);
            next_cycle();
            ex_multi_start = 0;
        end
        at_sample();
        check("m4_perf", stall_cycles, 32'd4);
        next_cycle();

        // N=1 causes no stall
        ex_multi_start  = 1;
        ex_multi_cycles = 6'd1;
        at_sample();
        check("m1_stall", 32'(stall), 32'h00);
        next_cycle();
        idle_inputs();
        at_sample();
        check("m1_busy", 32'(busy), 32'd0);
        next_cycle();

        // Flush in the middle of an N=10 sequence
        do_reset();
        ex_multi_start  = 1;
        ex_multi_cycles = 6'd10;
        next_cycle();
        idle_inputs();
        next_cycle();
        flush_req = 1;
        at_sample();
        check("fl_flush", 32'(flush), 32'd1);
        check("fl_stall", 32'(stall), 32'h00);
        next_cycle();
        flush_req = 0;
        for (int c = 0; c < 3; c++) begin
            at_sample();
            check("fl_busy_after",  32'(busy),  32'd0);
            check("fl_stall_after", 32'(stall), 32'h00);
            next_cycle();
        end
        at_sample();
        check("fl_perf", stall_cycles, 32'd2);
        next_cycle();

        // Back-to-back flush requests give back-to-back strobes
        flush_req = 1;
        at_sample();
        check("fl_b2b_0", 32'(flush), 32'd1);
        next_cycle();
        at_sample();
        check("fl_b2b_1", 32'(flush), 32'd1);
        next_cycle();
        flush_req = 0;

        // Start together with a load-use hazard: the multi stall wins for 3 cycles
        do_reset();
        ex_multi_start  = 1;
        ex_multi_cycles = 6'd3;
        set_load(5'd9, 1'b1);
        id_reg1_read = 1;
        id_reg1_addr = 5'd9;
        for (int c = 1; c <= 3; c++) begin
            at_sample();
            check("pr_stall", 32'(stall), 32'h0F);
            next_cycle();
            ex_multi_start = 0;
        end
        idle_inputs();
        at_sample();
        check("pr_stall_end", 32'(stall), 32'h00);
        next_cycle();

        // Flush, start and hazard together: flush only, no multi entry
        flush_req       = 1;
        ex_multi_start  = 1;
        ex_multi_cycles = 6'd3;
        set_load(5'd9, 1'b1);
        id_reg1_read = 1;
        id_reg1_addr = 5'd9;
        at_sample();
        check("pr_fl_flush", 32'(flush), 32'd1);
        check("pr_fl_stall", 32'(stall), 32'h00);
        next_cycle();
        idle_inputs();
        at_sample();
        check("pr_fl_busy",  32'(busy),  32'd0);
        check("pr_fl_stall2", 32'(stall), 32'h00);
        next_cycle();

        // Saturation: a 20-cycle op holds the 4-bit counter at 15
        do_reset();
        ex_multi_start  = 1;
        ex_multi_cycles = 6'd20;
        next_cycle();
        idle_inputs();
        for (int c = 0; c < 22; c++) begin
            next_cycle();
        end
        at_sample();
        check("sat_perf4",  32'(s_stall_cycles), 32'd15);
        check("sat_perf32", stall_cycles,        32'd20);
        check("sat_busy",   32'(busy),           32'd0);
        next_cycle();
        at_sample();
        check("sat_perf4_hold", 32'(s_stall_cycles), 32'd15);
        next_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
